// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, polarity normalisation and a
// 4-state debounce FSM per channel, producing a clean level plus single-cycle
// press/release pulses. Optional long-press detection is compiled in when the
// macro BUTTON_DEBOUNCE_LONG_PRESS_EN is defined; otherwise long_press is 0.
module button_debounce #(
  parameter int CLOCK_HZ          = 27_000_000,
  parameter int NUMBER_OF_BUTTONS = 2,
  parameter int DEBOUNCE_MS       = 10,
  parameter int LONG_PRESS_MS     = 1000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUMBER_OF_BUTTONS-1:0] button_in,
  output logic [NUMBER_OF_BUTTONS-1:0] button_out,
  output logic [NUMBER_OF_BUTTONS-1:0] pressed,
  output logic [NUMBER_OF_BUTTONS-1:0] released,
  output logic [NUMBER_OF_BUTTONS-1:0] long_press
);

  localparam int N     = NUMBER_OF_BUTTONS;
  localparam int D_RAW = (CLOCK_HZ / 1000) * DEBOUNCE_MS;
  localparam int D     = (D_RAW < 1) ? 1 : D_RAW;
  localparam int CW    = $clog2(D + 1);
  localparam logic [CW-1:0] D_LAST = CW'(D - 1);

  // Inactive pin level; also the value the synchroniser holds in reset so
  // that no phantom press is seen when reset is released.
  localparam logic INACTIVE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  logic [N-1:0] sync1_q, sync1_d;
  logic [N-1:0] sync2_q, sync2_d;
  logic [N-1:0] s;

  // Synchroniser next-state: shift the raw pins through two stages.
  always_comb begin
    sync1_d = button_in;
    sync2_d = sync1_q;
  end

  // Synchroniser flops, preset to the inactive pin level in reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= {N{INACTIVE}};
      sync2_q <= {N{INACTIVE}};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Normalised pressed level: 1 means the button is pressed.
  assign s = sync2_q ^ {N{INACTIVE}};

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          pr_q, pr_d;
    logic          rl_q, rl_d;

    // Debounce FSM: a level change is accepted only after D+1 equal samples.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      pr_d    = 1'b0;
      rl_d    = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (s[i]) begin
            state_d = ST_PRESS_WAIT;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PRESS_WAIT: begin
          if (!s[i]) begin
            state_d = ST_IDLE;
          end else if (cnt_q == D_LAST) begin
            state_d = ST_HELD;
            out_d   = 1'b1;
            pr_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_HELD: begin
          if (!s[i]) begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = '0;
          end else begin
            state_d = ST_HELD;
          end
        end
        ST_RELEASE_WAIT: begin
          if (s[i]) begin
            state_d = ST_HELD;
          end else if (cnt_q == D_LAST) begin
            state_d = ST_IDLE;
            out_d   = 1'b0;
            rl_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          out_d   = 1'b0;
        end
      endcase
    end

    // FSM state, counter and registered level/pulse outputs.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        out_q   <= 1'b0;
        pr_q    <= 1'b0;
        rl_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
        pr_q    <= pr_d;
        rl_q    <= rl_d;
      end
    end

    assign button_out[i] = out_q;
    assign pressed[i]    = pr_q;
    assign released[i]   = rl_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int L_RAW = (CLOCK_HZ / 1000) * LONG_PRESS_MS;
    localparam int L     = (L_RAW < 1) ? 1 : L_RAW;
    localparam int HW    = $clog2(L + 1);
    localparam logic [HW-1:0] L_FULL = HW'(L);
    localparam logic [HW-1:0] L_LAST = HW'(L - 1);

    logic [HW-1:0] hc_q, hc_d;
    logic          lp_q, lp_d;

    // Hold counter: restarts on press acceptance, keeps running through
    // release bounces, fires once at L-1 and then parks at L.
    always_comb begin
      hc_d = hc_q;
      lp_d = 1'b0;
      if ((state_q == ST_PRESS_WAIT) && (state_d == ST_HELD)) begin
        hc_d = '0;
      end else if ((state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT)) begin
        if (hc_q == L_LAST) begin
          hc_d = L_FULL;
          lp_d = 1'b1;
        end else if (hc_q < L_FULL) begin
          hc_d = hc_q + HW'(1);
        end else begin
          hc_d = hc_q;
        end
      end else begin
        hc_d = '0;
      end
    end

    // Hold counter and registered long-press pulse.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        hc_q <= '0;
        lp_q <= 1'b0;
      end else begin
        hc_q <= hc_d;
        lp_q <= lp_d;
      end
    end

    assign long_press[i] = lp_q;
`else
    assign long_press[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with D=4, L=20, active-low pins.
// Expected long-press behaviour follows BUTTON_DEBOUNCE_LONG_PRESS_EN.
module tb_button_debounce;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] button_in;
  logic [1:0] button_out;
  logic [1:0] pressed;
  logic [1:0] released;
  logic [1:0] long_press;

  button_debounce #(
    .CLOCK_HZ         (1000),
    .NUMBER_OF_BUTTONS(2),
    .DEBOUNCE_MS      (4),
    .LONG_PRESS_MS    (20),
    .ACTIVE_LOW       (1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .button_in (button_in),
    .button_out(button_out),
    .pressed   (pressed),
    .released  (released),
    .long_press(long_press)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [1:0] btn;
    logic [1:0] out;
    logic [1:0] pr;
    logic [1:0] rl;
    string      tag;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic push(input logic r, input logic [1:0] b, input logic [1:0] o,
                      input logic [1:0] p, input logic [1:0] l, input int n,
                      input string tag);
    vec_t v;
    v.rst = r; v.btn = b; v.out = o; v.pr = p; v.rl = l; v.tag = tag;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  int pr_cnt, pr_edge, rl_cnt, rl_edge, lp_cnt, lp_edge, drop_cnt, ch1_evt;
  int exp_lp_cnt, exp_lp_edge;

  initial begin
    reset     = 1'b1;
    button_in = 2'b11;

    // reset held with both pins pressed, then held through deassertion
    push(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3, "reset");
    push(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 6, "post_reset_wait");
    push(1'b0, 2'b00, 2'b11, 2'b11, 2'b00, 1, "dual_press");
    push(1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 3, "dual_hold");
    push(1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 6, "dual_rel_wait");
    push(1'b0, 2'b11, 2'b00, 2'b00, 2'b11, 1, "dual_release");
    push(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 3, "idle");
    // clean press/release on channel 0
    push(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 6, "c0_wait");
    push(1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 1, "c0_press");
    push(1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 4, "c0_hold");
    push(1'b0, 2'b11, 2'b01, 2'b00, 2'b00, 6, "c0_rel_wait");
    push(1'b0, 2'b11, 2'b00, 2'b00, 2'b01, 1, "c0_release");
    push(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2, "idle");
    // bounce on channel 0: 2-cycle toggles for 20 cycles, then settle
    for (int t = 0; t < 5; t++) begin
      push(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2, "bounce_lo");
      push(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2, "bounce_hi");
    end
    push(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 6, "settle_wait");
    push(1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 1, "settle_press");
    push(1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 2, "settle_hold");
    push(1'b0, 2'b11, 2'b01, 2'b00, 2'b00, 6, "settle_rel_wait");
    push(1'b0, 2'b11, 2'b00, 2'b00, 2'b01, 1, "settle_release");
    push(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2, "idle");
    // channel 1 alone
    push(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 6, "c1_wait");
    push(1'b0, 2'b01, 2'b10, 2'b10, 2'b00, 1, "c1_press");
    push(1'b0, 2'b11, 2'b10, 2'b00, 2'b00, 6, "c1_rel_wait");
    push(1'b0, 2'b11, 2'b00, 2'b00, 2'b10, 1, "c1_release");
    push(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2, "idle");
    // reset at edge 4 while in PRESS_WAIT, button kept held
    push(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 4, "pw_before_reset");
    push(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2, "mid_reset");
    push(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 6, "rst_wait");
    push(1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 1, "rst_press");
    push(1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1, "rst_hold");
    push(1'b0, 2'b11, 2'b01, 2'b00, 2'b00, 6, "rst_rel_wait");
    push(1'b0, 2'b11, 2'b00, 2'b00, 2'b01, 1, "rst_release");
    push(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 3, "idle");

    foreach (vecs[i]) begin
      reset     = vecs[i].rst;
      button_in = vecs[i].btn;
      @(posedge clock); #1;
      n_checks++;
      if ({button_out, pressed, released, long_press} ==
          {vecs[i].out, vecs[i].pr, vecs[i].rl, 2'b00}) begin
        n_pass++;
      end else begin
        $display("FAIL vec%0d %s: got out=%b pr=%b rl=%b lp=%b expected out=%b pr=%b rl=%b lp=00",
                 i, vecs[i].tag, button_out, pressed, released, long_press,
                 vecs[i].out, vecs[i].pr, vecs[i].rl);
      end
    end

    // long press with a 2-cycle release glitch at hold cycle 10, release at 40
    pr_cnt = 0; pr_edge = -1; rl_cnt = 0; rl_edge = -1;
    lp_cnt = 0; lp_edge = -1; drop_cnt = 0; ch1_evt = 0;
    for (int k = 0; k < 56; k++) begin
      if (k == 16 || k == 17 || k >= 40) button_in = 2'b11;
      else                               button_in = 2'b10;
      @(posedge clock); #1;
      if (pressed[0])    begin pr_cnt++; pr_edge = k; end
      if (released[0])   begin rl_cnt++; rl_edge = k; end
      if (long_press[0]) begin lp_cnt++; lp_edge = k; end
      if (k >= 6 && k < 46 && !button_out[0]) drop_cnt++;
      if (pressed[1] || released[1] || long_press[1] || button_out[1]) ch1_evt++;
    end
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    exp_lp_cnt = 1; exp_lp_edge = 26;
`else
    exp_lp_cnt = 0; exp_lp_edge = -1;
`endif
    check("lp_pressed_count", pr_cnt, 1);
    check("lp_pressed_edge", pr_edge, 6);
    check("lp_level_held", drop_cnt, 0);
    check("lp_long_count", lp_cnt, exp_lp_cnt);
    check("lp_long_edge", lp_edge, exp_lp_edge);
    check("lp_released_count", rl_cnt, 1);
    check("lp_released_edge", rl_edge, 46);
    check("lp_ch1_quiet", ch1_evt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
